// File: rtl/frame_sequencer.sv
// frame_sequencer: runs one frame through the Gaussian convolution stage, then the corner-detection stage,
// with a bounded wait on each stage and error/abort handling.
module frame_sequencer #(
    parameter int MAX_KERNEL = 3,
    parameter int X_MAX      = 200,
    parameter int Y_MAX      = 200,
    parameter int TIMEOUT    = 65535
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(X_MAX)-1:0]      cfg_max_x,
    input  logic [$clog2(Y_MAX)-1:0]      cfg_max_y,
    input  logic [2:0]                    cfg_sigma,
    input  logic [$clog2(MAX_KERNEL)-1:0] cfg_kernel_size,
    output logic                          conv_new_trans,
    output logic [$clog2(X_MAX)-1:0]      conv_max_x,
    output logic [$clog2(Y_MAX)-1:0]      conv_max_y,
    output logic [2:0]                    conv_sigma,
    output logic [$clog2(MAX_KERNEL)-1:0] conv_kernel_size,
    input  logic                          conv_done,
    output logic                          fast_start,
    input  logic                          fast_done,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err,
    output logic [1:0]                    err_code
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CONV_KICK, CONV_WAIT, FAST_KICK, FAST_WAIT, DONE, ERR} state_t;

    state_t                        r_state, w_next;
    logic [CW-1:0]                 r_cnt;
    logic [1:0]                    r_err_code, w_err_code;
    logic [$clog2(X_MAX)-1:0]      r_max_x;
    logic [$clog2(Y_MAX)-1:0]      r_max_y;
    logic [2:0]                    r_sigma;
    logic [$clog2(MAX_KERNEL)-1:0] r_kernel;
    logic                          w_cfg_ok, w_accept, w_timeout;

    assign w_cfg_ok  = cfg_kernel_size[0] && (32'(cfg_kernel_size) <= MAX_KERNEL) &&
                       cfg_sigma != 3'd0 && cfg_max_x != '0 && cfg_max_y != '0;
    assign w_timeout = r_cnt == CW'(TIMEOUT);

    // Abort outranks everything once busy; a stage's done outranks its timeout.
    always_comb begin
        w_next     = r_state;
        w_err_code = r_err_code;
        w_accept   = 1'b0;
        if (abort && r_state != IDLE)
            w_next = IDLE;
        else
            case (r_state)
                IDLE: if (start && !abort) begin
                    w_accept   = w_cfg_ok;
                    w_next     = w_cfg_ok ? CONV_KICK : ERR;
                    w_err_code = w_cfg_ok ? 2'b00 : 2'b01;
                end
                CONV_KICK: w_next = CONV_WAIT;
                CONV_WAIT: if (conv_done) w_next = FAST_KICK;
                    else if (w_timeout) begin
                        w_next     = ERR;
                        w_err_code = 2'b10;
                    end
                FAST_KICK: w_next = FAST_WAIT;
                FAST_WAIT: if (fast_done) w_next = DONE;
                    else if (w_timeout) begin
                        w_next     = ERR;
                        w_err_code = 2'b11;
                    end
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_err_code <= 2'b00;
            r_max_x    <= '0;
            r_max_y    <= '0;
            r_sigma    <= '0;
            r_kernel   <= '0;
        end else begin
            r_state    <= w_next;
            r_err_code <= w_err_code;
            r_cnt      <= (r_state == CONV_WAIT || r_state == FAST_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_max_x  <= cfg_max_x;
                r_max_y  <= cfg_max_y;
                r_sigma  <= cfg_sigma;
                r_kernel <= cfg_kernel_size;
            end
        end
    end

    assign conv_new_trans   = r_state == CONV_KICK;
    assign fast_start       = r_state == FAST_KICK;
    assign frame_done       = r_state == DONE;
    assign err              = r_state == ERR;
    assign busy             = r_state != IDLE;
    assign err_code         = r_err_code;
    assign conv_max_x       = r_max_x;
    assign conv_max_y       = r_max_y;
    assign conv_sigma       = r_sigma;
    assign conv_kernel_size = r_kernel;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized frames against an event-timeline model; a monitor pops expected pulses.
module tb_frame_sequencer;
    localparam int T = 8;

    logic       clk = 0, n_rst = 0, start = 0, abort = 0, conv_done = 0, fast_done = 0;
    logic [7:0] cfg_max_x = 0, cfg_max_y = 0;
    logic [2:0] cfg_sigma = 0;
    logic [1:0] cfg_kernel_size = 0;
    logic       conv_new_trans, fast_start, busy, frame_done, err;
    logic [7:0] conv_max_x, conv_max_y;
    logic [2:0] conv_sigma;
    logic [1:0] conv_kernel_size, err_code;

    frame_sequencer #(.MAX_KERNEL(3), .X_MAX(200), .Y_MAX(200), .TIMEOUT(T)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .cfg_max_x(cfg_max_x), .cfg_max_y(cfg_max_y), .cfg_sigma(cfg_sigma),
        .cfg_kernel_size(cfg_kernel_size), .conv_new_trans(conv_new_trans),
        .conv_max_x(conv_max_x), .conv_max_y(conv_max_y), .conv_sigma(conv_sigma),
        .conv_kernel_size(conv_kernel_size), .conv_done(conv_done), .fast_start(fast_start),
        .fast_done(fast_done), .busy(busy), .frame_done(frame_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // kinds: 0 conv kick, 1 fast kick, 2 frame done, 3 error
    typedef struct {
        int         c;
        int         k;
        logic [1:0] code;
        logic [7:0] mx, my;
        logic [2:0] sg;
        logic [1:0] ks;
    } ev_t;

    ev_t q[$];
    bit  exp_busy[int];
    int  cyc = 0, tests = 0, fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int k, input logic [1:0] code,
                               input logic [7:0] mx, my, input logic [2:0] sg, input logic [1:0] ks);
        ev_t e;
        e.c = c; e.k = k; e.code = code; e.mx = mx; e.my = my; e.sg = sg; e.ks = ks;
        return e;
    endfunction

    function automatic bit cfg_ok(input logic [7:0] mx, my, input logic [2:0] sg, input logic [1:0] ks);
        return (ks % 2 == 1) && ks <= 3 && sg != 0 && mx != 0 && my != 0;
    endfunction

    task automatic chk(input string n, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d (cyc %0d)", n, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        int  np, k;
        ev_t e;
        if (n_rst) begin
            np = int'(conv_new_trans) + int'(fast_start) + int'(frame_done) + int'(err);
            k  = conv_new_trans ? 0 : fast_start ? 1 : frame_done ? 2 : 3;
            if (exp_busy.exists(cyc)) begin
                tests++;
                if (busy !== exp_busy[cyc]) begin
                    fails++;
                    $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy[cyc]);
                end
            end
            if (np > 0) begin
                tests++;
                if (np > 1 || q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse cyc=%0d got kind=%0d pulses=%0d expected none", cyc, k, np);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.k != k || e.code !== err_code ||
                        (e.k != 3 && {e.mx, e.my, e.sg, e.ks} !== {conv_max_x, conv_max_y, conv_sigma, conv_kernel_size})) begin
                        fails++;
                        $display("FAIL event got kind=%0d cyc=%0d code=%0d cfg=%0d/%0d/%0d/%0d expected kind=%0d cyc=%0d code=%0d cfg=%0d/%0d/%0d/%0d",
                                 k, cyc, err_code, conv_max_x, conv_max_y, conv_sigma, conv_kernel_size,
                                 e.k, e.c, e.code, e.mx, e.my, e.sg, e.ks);
                    end
                end
            end
        end
    end

    // abort_mode: -1 none, -2 random, -3 on the fast_done edge
    task automatic run_frame(input logic [7:0] mx, my, input logic [2:0] sg, input logic [1:0] ks,
                             input int dconv, dfast, abort_mode, input bit restart);
        ev_t loc[$];
        int  s, ce, fe, e_end, a, rs, bend, last;
        bit  good;
        good = cfg_ok(mx, my, sg, ks);
        ce = -100; fe = -100; a = -1; rs = -1;
        @(negedge clk);
        s = cyc + 1;
        if (!good) begin
            loc.push_back(mk(s, 3, 2'b01, mx, my, sg, ks));
            e_end = s;
        end else begin
            loc.push_back(mk(s, 0, 2'b00, mx, my, sg, ks));
            ce = s + 2 + dconv;
            if (dconv <= T) begin
                loc.push_back(mk(ce, 1, 2'b00, mx, my, sg, ks));
                fe = ce + 2 + dfast;
                if (dfast <= T) begin
                    loc.push_back(mk(fe, 2, 2'b00, mx, my, sg, ks));
                    e_end = fe;
                end else begin
                    e_end = ce + 2 + T;
                    loc.push_back(mk(e_end, 3, 2'b11, mx, my, sg, ks));
                end
            end else begin
                e_end = s + 2 + T;
                loc.push_back(mk(e_end, 3, 2'b10, mx, my, sg, ks));
            end
        end
        if (abort_mode == -3) a = fe;
        else if (abort_mode == -2 && $urandom_range(0, 3) == 0) a = int'($urandom_range(s + 1, e_end + 1));
        if (restart) rs = int'($urandom_range(s + 1, a > 0 ? a : e_end + 1));
        foreach (loc[i]) if (a < 0 || loc[i].c < a) q.push_back(loc[i]);
        bend = (a > 0 && a <= e_end) ? a - 1 : e_end;
        last = e_end;
        if (ce > last) last = ce;
        if (fe > last) last = fe;
        if (a > last) last = a;
        if (rs > last) last = rs;
        last += 2;
        cfg_max_x = mx; cfg_max_y = my; cfg_sigma = sg; cfg_kernel_size = ks;
        for (int k = s; k <= last; k++) begin
            if (k > s) @(negedge clk);
            start     = (k == s) || (k == rs);
            conv_done = k == ce;
            fast_done = k == fe;
            abort     = k == a;
            if (k == rs) begin
                cfg_max_x = ~mx; cfg_max_y = my + 8'd1; cfg_sigma = sg ^ 3'd5; cfg_kernel_size = ks ^ 2'd2;
            end
            exp_busy[k] = k >= s && k <= bend;
        end
        @(negedge clk);
        start = 0; conv_done = 0; fast_done = 0; abort = 0;
        chk("missing_events", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int s;
        logic [7:0] mx, my;
        logic [2:0] sg;
        logic [1:0] ks;
        int r;
        repeat (2) @(negedge clk);
        chk("reset_outs", int'({busy, conv_new_trans, fast_start, frame_done, err, err_code}), 0);
        chk("reset_conv", int'({conv_max_x, conv_max_y, conv_sigma, conv_kernel_size}), 0);
        n_rst = 1;

        run_frame(8'd99, 8'd99, 3'd2, 2'd3, 5, 3, -1, 0);
        run_frame(8'd99, 8'd99, 3'd2, 2'd2, 0, 0, -1, 0);
        chk("err_code_hold_01", int'(err_code), 1);
        run_frame(8'd99, 8'd99, 3'd2, 2'd3, T + 1, 0, -1, 0);
        chk("err_code_hold_10", int'(err_code), 2);
        run_frame(8'd99, 8'd99, 3'd2, 2'd3, T, 2, -1, 0);
        run_frame(8'd10, 8'd20, 3'd5, 2'd1, 1, T + 2, -1, 0);
        chk("err_code_hold_11", int'(err_code), 3);
        run_frame(8'd10, 8'd20, 3'd5, 2'd1, 2, 4, -3, 1);

        // abort and start together while idle: start must be ignored
        @(negedge clk);
        cfg_max_x = 8'd5; cfg_max_y = 8'd5; cfg_sigma = 3'd1; cfg_kernel_size = 2'd1;
        start = 1; abort = 1; exp_busy[cyc + 1] = 0;
        @(negedge clk);
        start = 0; abort = 0; exp_busy[cyc + 1] = 0;
        repeat (2) @(negedge clk);
        chk("abort_start_idle_busy", int'(busy), 0);

        // asynchronous reset while waiting on convolution
        @(negedge clk);
        cfg_max_x = 8'd99; cfg_max_y = 8'd99; cfg_sigma = 3'd2; cfg_kernel_size = 2'd3;
        start = 1; s = cyc + 1; exp_busy[s] = 1;
        q.push_back(mk(s, 0, 2'b00, 8'd99, 8'd99, 3'd2, 2'd3));
        @(negedge clk);
        start = 0; exp_busy[s + 1] = 1;
        @(negedge clk);
        exp_busy[s + 2] = 1;
        @(negedge clk);
        #2 n_rst = 0;
        #1 chk("rst_async_outs", int'({busy, conv_new_trans, fast_start, frame_done, err, err_code}), 0);
        chk("rst_async_conv", int'({conv_max_x, conv_max_y, conv_sigma, conv_kernel_size}), 0);
        @(negedge clk);
        n_rst = 1;
        for (int i = 0; i < 5; i++) begin
            conv_done = i == 0;
            fast_done = i == 1;
            exp_busy[cyc + 1] = 0;
            @(negedge clk);
        end
        conv_done = 0; fast_done = 0;
        chk("rst_no_events", q.size(), 0);
        chk("rst_idle_after_stray", int'(busy), 0);

        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            mx = (r == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            my = (r == 1) ? 8'd0 : 8'($urandom_range(1, 255));
            sg = (r == 2) ? 3'd0 : 3'($urandom_range(1, 7));
            ks = (r == 3) ? 2'($urandom_range(0, 1) * 2) : ($urandom_range(0, 1) == 1 ? 2'd1 : 2'd3);
            run_frame(mx, my, sg, ks, int'($urandom_range(0, T + 3)), int'($urandom_range(0, T + 3)),
                      -2, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
